// File: rtl/hazard_monitor.sv
// hazard_monitor: per-channel monitor for counter values that cross into this
// clock domain asynchronously. Each channel synchronizes its counter, then
// flags any step other than +0 or +1 (modulo 2^WID) as a hazard.
//
// Ports:
//   clk           sole clock
//   resetn        asynchronous active-low reset
//   enable        monitoring enable; low forces IDLE
//   clear         synchronous clear of flags/counters, re-primes the baseline
//   din           NCH packed async counters, channel c at [c*WID +: WID]
//   hazard        per-channel one-cycle hazard pulse (registered)
//   any_hazard    OR of hazard
//   hazard_sticky per-channel latched hazard flag
//   hazard_cnt    per-channel saturating hazard count, packed like din
//   state         FSM state: IDLE=0, PRIME=1, RUN=2
//
// Build option: HAZARD_MONITOR_GRAY_EN -- when defined, synchronized samples
// are treated as Gray code and converted to binary before the delta check.

// Per-channel lane: synchronizer, baseline, delta check, sticky flag, counter.
module hazard_monitor_ch #(
  parameter int unsigned WID         = 4,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned CNT_WID     = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [WID-1:0]     din_i,
  input  logic               load_i,
  input  logic               check_i,
  input  logic               clear_i,
  output logic               hazard_o,
  output logic               sticky_o,
  output logic [CNT_WID-1:0] cnt_o
);
  logic [SYNC_STAGES-1:0][WID-1:0] sync_q;
  logic [WID-1:0]     raw, sample, delta;
  logic [WID-1:0]     dbuf_q, dbuf_d;
  logic               haz_q, haz_d;
  logic               sticky_q, sticky_d;
  logic [CNT_WID-1:0] cnt_q, cnt_d;
  logic               illegal;

  // Chain always shifts, regardless of FSM state, so it is full by the time
  // PRIME finishes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
  end

  assign raw = sync_q[SYNC_STAGES-1];

`ifdef HAZARD_MONITOR_GRAY_EN
  // Binary bit i is the XOR of all Gray bits at or above i.
  for (genvar i = 0; i < WID; i++) begin : g_gray
    assign sample[i] = ^raw[WID-1:i];
  end
`else
  assign sample = raw;
`endif

  // Legal steps are 0 and 1 modulo 2^WID; the subtraction wraps naturally.
  assign delta   = sample - dbuf_q;
  assign illegal = (delta[WID-1:1] != '0);

  always_comb begin
    dbuf_d   = dbuf_q;
    haz_d    = 1'b0;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (load_i || check_i) dbuf_d = sample;
    if (clear_i) begin
      // Clear beats any hazard detected in the same cycle.
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (check_i && illegal) begin
      haz_d    = 1'b1;
      sticky_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WID'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dbuf_q   <= '0;
      haz_q    <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      dbuf_q   <= dbuf_d;
      haz_q    <= haz_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign hazard_o = haz_q;
  assign sticky_o = sticky_q;
  assign cnt_o    = cnt_q;
endmodule

module hazard_monitor #(
  parameter int unsigned WID         = 4,
  parameter int unsigned NCH         = 2,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned CNT_WID     = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [NCH*WID-1:0]     din,
  output logic [NCH-1:0]         hazard,
  output logic                   any_hazard,
  output logic [NCH-1:0]         hazard_sticky,
  output logic [NCH*CNT_WID-1:0] hazard_cnt,
  output logic [1:0]             state
);
  localparam int unsigned PW = (SYNC_STAGES > 1) ? $clog2(SYNC_STAGES) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  state_t        state_q;
  logic [PW-1:0] pcnt_q;
  logic          prime_done, load, check;

  assign prime_done = (pcnt_q == PW'(SYNC_STAGES - 1));

  // Baseline loads on the PRIME->RUN edge; checks only happen in cycles that
  // keep the FSM in RUN, so hazard can only be seen while state reads RUN.
  assign load  = (state_q == PRIME) && enable && !clear && prime_done;
  assign check = (state_q == RUN)   && enable && !clear;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
    end else if (!enable) begin
      state_q <= IDLE;
      pcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= PRIME;
          pcnt_q  <= '0;
        end
        PRIME: begin
          if (clear) begin
            pcnt_q <= '0;
          end else if (prime_done) begin
            state_q <= RUN;
            pcnt_q  <= '0;
          end else begin
            pcnt_q <= pcnt_q + PW'(1);
          end
        end
        RUN: begin
          if (clear) begin
            state_q <= PRIME;
            pcnt_q  <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          pcnt_q  <= '0;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    hazard_monitor_ch #(
      .WID(WID), .SYNC_STAGES(SYNC_STAGES), .CNT_WID(CNT_WID)
    ) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .din_i    (din[c*WID +: WID]),
      .load_i   (load),
      .check_i  (check),
      .clear_i  (clear),
      .hazard_o (hazard[c]),
      .sticky_o (hazard_sticky[c]),
      .cnt_o    (hazard_cnt[c*CNT_WID +: CNT_WID])
    );
  end

  assign any_hazard = |hazard;
  assign state      = state_q;
endmodule

// File: tb/tb_hazard_monitor.sv
module tb_hazard_monitor;
  logic        clk = 1'b0;
  logic        resetn, enable, clear;
  logic [7:0]  din;
  logic [1:0]  hazard, hazard_sticky, state;
  logic        any_hazard;
  logic [15:0] hazard_cnt;
  int checks = 0;
  int errors = 0;

  hazard_monitor dut (
    .clk(clk), .resetn(resetn), .enable(enable), .clear(clear), .din(din),
    .hazard(hazard), .any_hazard(any_hazard), .hazard_sticky(hazard_sticky),
    .hazard_cnt(hazard_cnt), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL rst_hazard got %b want 00", hazard); end
    checks++; if (any_hazard !== 1'b0) begin errors++; $display("FAIL rst_any got %b want 0", any_hazard); end
    checks++; if (hazard_sticky !== 2'b00) begin errors++; $display("FAIL rst_sticky got %b want 00", hazard_sticky); end
    checks++; if (hazard_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt got %h want 0000", hazard_cnt); end
    resetn = 1'b1;
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_no_en got %0d want 0", state); end
    enable = 1'b1;
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL to_prime got %0d want 1", state); end
    tick(); tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL prime_hold got %0d want 1", state); end
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL to_run got %0d want 2", state); end
  endtask

  task automatic test_count_seq();
    for (int v = 1; v <= 16; v++) begin
      din[3:0] = 4'(v);
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL seq_hazard v=%0d got %b want 00", v, hazard); end
      end
    end
    checks++; if (hazard_cnt !== 16'h0) begin errors++; $display("FAIL seq_cnt got %h want 0000", hazard_cnt); end
    checks++; if (hazard_sticky !== 2'b00) begin errors++; $display("FAIL seq_sticky got %b want 00", hazard_sticky); end
  endtask

  task automatic test_jump();
    for (int v = 1; v <= 5; v++) begin
      din[3:0] = 4'(v);
      repeat (4) tick();
    end
    din[3:0] = 4'd7;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL jump_early k=%0d got %b want 00", k, hazard); end
    end
    tick();
    checks++; if (hazard !== 2'b01) begin errors++; $display("FAIL jump_pulse got %b want 01", hazard); end
    checks++; if (any_hazard !== 1'b1) begin errors++; $display("FAIL jump_any got %b want 1", any_hazard); end
    tick();
    checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL jump_one_cycle got %b want 00", hazard); end
    checks++; if (hazard_sticky !== 2'b01) begin errors++; $display("FAIL jump_sticky got %b want 01", hazard_sticky); end
    checks++; if (hazard_cnt !== 16'h0001) begin errors++; $display("FAIL jump_cnt got %h want 0001", hazard_cnt); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 100; i++) begin din[7:4] = din[7:4] ^ 4'h8; tick(); end
    repeat (5) tick();
    checks++; if (hazard_cnt[15:8] !== 8'd100) begin errors++; $display("FAIL sat_mid got %0d want 100", hazard_cnt[15:8]); end
    checks++; if (hazard_sticky !== 2'b11) begin errors++; $display("FAIL sat_sticky got %b want 11", hazard_sticky); end
    for (int i = 0; i < 200; i++) begin din[7:4] = din[7:4] ^ 4'h8; tick(); end
    repeat (5) tick();
    checks++; if (hazard_cnt[15:8] !== 8'd255) begin errors++; $display("FAIL sat_top got %0d want 255", hazard_cnt[15:8]); end
    checks++; if (hazard_cnt[7:0] !== 8'd1) begin errors++; $display("FAIL sat_ch0 got %0d want 1", hazard_cnt[7:0]); end
  endtask

  task automatic test_clear();
    din[3:0] = 4'd10;
    tick(); tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL clr_hazard got %b want 00", hazard); end
    checks++; if (hazard_sticky !== 2'b00) begin errors++; $display("FAIL clr_sticky got %b want 00", hazard_sticky); end
    checks++; if (hazard_cnt !== 16'h0) begin errors++; $display("FAIL clr_cnt got %h want 0000", hazard_cnt); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL clr_state got %0d want 1", state); end
    tick(); tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL clr_prime got %0d want 1", state); end
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL clr_rerun got %0d want 2", state); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL clr_after k=%0d got %b want 00", k, hazard); end
    end
  endtask

  task automatic test_reset_mid();
    din[7:4] = 4'd5;
    repeat (4) tick();
    checks++; if (hazard !== 2'b10) begin errors++; $display("FAIL rm_pre_hazard got %b want 10", hazard); end
    #2;
    din[3:0] = 4'd9;
    resetn = 1'b0;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rm_state got %0d want 0", state); end
    checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL rm_hazard got %b want 00", hazard); end
    checks++; if (hazard_sticky !== 2'b00) begin errors++; $display("FAIL rm_sticky got %b want 00", hazard_sticky); end
    checks++; if (hazard_cnt !== 16'h0) begin errors++; $display("FAIL rm_cnt got %h want 0000", hazard_cnt); end
    #2;
    resetn = 1'b1;
    repeat (4) tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rm_rerun got %0d want 2", state); end
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL rm_after k=%0d got %b want 00", k, hazard); end
    end
  endtask

  task automatic test_enable_hold();
    din[3:0] = 4'd12;
    repeat (4) tick();
    checks++; if (hazard !== 2'b01) begin errors++; $display("FAIL en_pulse got %b want 01", hazard); end
    enable = 1'b0;
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL en_idle got %0d want 0", state); end
    din[3:0] = 4'd3;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL en_off k=%0d got %b want 00", k, hazard); end
    end
    checks++; if (hazard_cnt !== 16'h0001) begin errors++; $display("FAIL en_hold_cnt got %h want 0001", hazard_cnt); end
    checks++; if (hazard_sticky !== 2'b01) begin errors++; $display("FAIL en_hold_sticky got %b want 01", hazard_sticky); end
    enable = 1'b1;
    repeat (4) tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL en_rerun got %0d want 2", state); end
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL en_after k=%0d got %b want 00", k, hazard); end
    end
    checks++; if (hazard_cnt !== 16'h0001) begin errors++; $display("FAIL en_final_cnt got %h want 0001", hazard_cnt); end
    checks++; if (hazard_sticky !== 2'b01) begin errors++; $display("FAIL en_final_sticky got %b want 01", hazard_sticky); end
  endtask

  task automatic test_gray();
    logic [3:0] seq [3];
    seq[0] = 4'b0001; seq[1] = 4'b0011; seq[2] = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      din[3:0] = seq[i];
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++; if (hazard !== 2'b00) begin errors++; $display("FAIL gray_seq i=%0d got %b want 00", i, hazard); end
      end
    end
    checks++; if (hazard_cnt !== 16'h0) begin errors++; $display("FAIL gray_seq_cnt got %h want 0000", hazard_cnt); end
    #2;
    din[3:0] = 4'b0001;
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    repeat (4) tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL gray_rerun got %0d want 2", state); end
    din[3:0] = 4'b0010;
    repeat (4) tick();
    checks++; if (hazard !== 2'b01) begin errors++; $display("FAIL gray_jump got %b want 01", hazard); end
    tick();
    checks++; if (hazard_cnt !== 16'h0001) begin errors++; $display("FAIL gray_cnt got %h want 0001", hazard_cnt); end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; clear = 1'b0; din = 8'h00;
    test_reset();
`ifdef HAZARD_MONITOR_GRAY_EN
    test_gray();
`else
    test_count_seq();
    test_jump();
    test_saturate();
    test_clear();
    test_reset_mid();
    test_enable_hold();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
